// File: rtl/lpf_pixel_fifo.sv
// Credit-based pixel FIFO between the LPF read stage and the projective transform.
// Optional coordinate-sequence checking is enabled by defining LPF_FIFO_SEQ_CHECK_EN.
module lpf_pixel_fifo #(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3,
  parameter int PIX_W     = 18,
  parameter int NUM_PIX   = 307200
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_flag,
  output logic                 request,
  input  logic [PIX_W-1:0]     pixel_in,
  input  logic [9:0]           x_in,
  input  logic [8:0]           y_in,
  input  logic                 pixel_flag_in,
  output logic [PIX_W-1:0]     out_pixel,
  output logic [9:0]           out_x,
  output logic [8:0]           out_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_done,
  output logic [LOG_DEPTH:0]   level,
  output logic                 seq_err
);

  localparam int W = PIX_W + 19;
  localparam logic [LOG_DEPTH:0]   FULL = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH+1:0] CAP  = (LOG_DEPTH+2)'(DEPTH);
  localparam logic [18:0]          LAST = 19'(NUM_PIX - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    DRAIN
  } state_t;

  state_t state;

  logic [W-1:0]         mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH-1:0] rd_next;
  logic [LOG_DEPTH:0]   inflight;
  logic [LOG_DEPTH:0]   head_level;
  logic [LOG_DEPTH:0]   next_level;
  logic [LOG_DEPTH:0]   lvl_push;
  logic [LOG_DEPTH:0]   lvl_pop;
  logic [LOG_DEPTH:0]   lvl_req;
  logic [LOG_DEPTH+1:0] credit;
  logic [18:0]          req_cnt;
  logic                 live;
  logic                 ret;
  logic                 accept;
  logic                 push;
  logic                 pop;

  // Requests only go out while level + inflight leaves room for every return.
  assign credit  = {1'b0, level} + {1'b0, inflight};
  assign request = (state == RUN) && (credit < CAP) && (req_cnt <= LAST);

  assign live   = (state == RUN) || (state == DONE);
  assign ret    = pixel_flag_in && (inflight != '0);
  assign accept = ret && live && !frame_flag;
  assign pop    = out_valid && out_ready;
  assign push   = accept && ((level != FULL) || pop);

  assign rd_next    = rd_ptr + LOG_DEPTH'(1);
  assign lvl_push   = {{LOG_DEPTH{1'b0}}, push};
  assign lvl_pop    = {{LOG_DEPTH{1'b0}}, pop};
  assign lvl_req    = {{LOG_DEPTH{1'b0}}, request};
  assign head_level = level - lvl_pop;
  assign next_level = head_level + lvl_push;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {x_in, y_in, pixel_in};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      inflight   <= '0;
      req_cnt    <= '0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_x      <= '0;
      out_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      inflight   <= inflight + lvl_req - {{LOG_DEPTH{1'b0}}, ret};
      frame_done <= pop && (out_x == 10'd639) && (out_y == 9'd479);
      if (frame_flag) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        req_cnt   <= '0;
        out_valid <= 1'b0;
        state     <= (state == IDLE) ? RUN : DRAIN;
      end else begin
        level     <= next_level;
        out_valid <= (next_level != '0);
        if (push) begin
          wr_ptr <= wr_ptr + LOG_DEPTH'(1);
        end
        if (pop) begin
          rd_ptr <= rd_next;
        end
        // The head register is refilled from the input when the FIFO behind it is empty.
        if (push && (head_level == '0)) begin
          {out_x, out_y, out_pixel} <= {x_in, y_in, pixel_in};
        end else if (pop && (head_level != '0)) begin
          {out_x, out_y, out_pixel} <= mem[rd_next];
        end
        if (request) begin
          req_cnt <= req_cnt + 19'd1;
        end
        unique case (state)
          IDLE: state <= IDLE;
          RUN: begin
            if (request && (req_cnt == LAST)) begin
              state <= DONE;
            end
          end
          DONE: state <= DONE;
          DRAIN: begin
            if (inflight == '0) begin
              state   <= RUN;
              req_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef LPF_FIFO_SEQ_CHECK_EN
  logic [9:0] exp_x;
  logic [8:0] exp_y;
  logic       err;

  always_ff @(posedge clock) begin
    if (reset) begin
      exp_x <= '0;
      exp_y <= '0;
      err   <= 1'b0;
    end else if (frame_flag) begin
      exp_x <= '0;
      exp_y <= '0;
    end else if (push) begin
      if ((x_in != exp_x) || (y_in != exp_y)) begin
        err <= 1'b1;
      end
      if (exp_x == 10'd639) begin
        exp_x <= '0;
        exp_y <= (exp_y == 9'd479) ? 9'd0 : exp_y + 9'd1;
      end else begin
        exp_x <= exp_x + 10'd1;
      end
    end
  end

  assign seq_err = err;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_lpf_pixel_fifo.sv
// Directed bench for lpf_pixel_fifo: vector table plus an in-order LPF return model.
// Build with LPF_FIFO_SEQ_CHECK_EN to also exercise the sequence checker.
module tb_lpf_pixel_fifo;

  localparam int FRAME = 307200;
  localparam int NPIX  = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_flag;
  logic        request;
  logic [17:0] pixel_in;
  logic [9:0]  x_in;
  logic [8:0]  y_in;
  logic        pixel_flag_in;
  logic [17:0] out_pixel;
  logic [9:0]  out_x;
  logic [8:0]  out_y;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;
  logic [3:0]  level;
  logic        seq_err;

  lpf_pixel_fifo #(
    .DEPTH(8),
    .LOG_DEPTH(3),
    .PIX_W(18),
    .NUM_PIX(NPIX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .frame_flag(frame_flag),
    .request(request),
    .pixel_in(pixel_in),
    .x_in(x_in),
    .y_in(y_in),
    .pixel_flag_in(pixel_flag_in),
    .out_pixel(out_pixel),
    .out_x(out_x),
    .out_y(out_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_done(frame_done),
    .level(level),
    .seq_err(seq_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  bit auto_en;
  int lat_min, lat_max;
  int due_q[$];
  int idx_q[$];
  int next_idx, pop_idx, base_idx;
  int corrupt_idx = -1;
  int cyc, req_seen, pops, order_errs, max_level;
  int fd_count, fd_bad, last_pop_idx;

  typedef struct {
    bit ff;
    bit pf;
    bit rdy;
    int x;
    bit e_req;
    bit e_val;
    int e_level;
    int e_x;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with this cycle's inputs set; returns at the next negedge.
  task automatic step();
    int d;
    if (int'(level) > max_level) max_level = int'(level);
    if (frame_done) begin
      fd_count++;
      if (last_pop_idx != FRAME - 1) fd_bad++;
    end
    if (out_valid && out_ready) begin
      if (out_x !== 10'(pop_idx % 640) || out_y !== 9'(pop_idx / 640) ||
          out_pixel !== 18'(pop_idx)) order_errs++;
      last_pop_idx = pop_idx;
      pop_idx++;
      pops++;
    end
    if (request) req_seen++;
    if (auto_en) begin
      pixel_flag_in = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        d = idx_q[0];
        x_in = 10'(d % 640);
        if (d == corrupt_idx) x_in = x_in + 10'd1;
        y_in = 9'(d / 640);
        pixel_in = 18'(d);
        pixel_flag_in = 1'b1;
        void'(due_q.pop_front());
        void'(idx_q.pop_front());
      end
      if (request) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (due_q.size() > 0 && d <= due_q[$]) d = due_q[$] + 1;
        due_q.push_back(d);
        idx_q.push_back(next_idx);
        next_idx++;
      end
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_flag = 1'b0;
    pixel_flag_in = 1'b0;
    out_ready = 1'b0;
    x_in = '0;
    y_in = '0;
    pixel_in = '0;
    auto_en = 1'b0;
    due_q.delete();
    idx_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    req_seen = 0;
    pops = 0;
    order_errs = 0;
    max_level = 0;
    fd_count = 0;
    fd_bad = 0;
    last_pop_idx = -1;
  endtask

  task automatic start_frame();
    frame_flag = 1'b1;
    step();
    frame_flag = 1'b0;
    next_idx = base_idx;
    pop_idx = base_idx;
    pops = 0;
    req_seen = 0;
  endtask

  initial begin
    int n;
    int nz;
    cyc = 0;
    base_idx = 0;
    lat_min = 4;
    lat_max = 4;

    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, -1};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, -1};
    tbl[2]  = '{0, 0, 0, 0, 1, 0, 0, -1};
    tbl[3]  = '{0, 0, 0, 0, 1, 0, 0, -1};
    tbl[4]  = '{0, 1, 0, 0, 1, 0, 0, -1};
    tbl[5]  = '{0, 1, 0, 1, 1, 1, 1, 0};
    tbl[6]  = '{0, 0, 1, 0, 1, 1, 2, 0};
    tbl[7]  = '{0, 1, 1, 2, 1, 1, 1, 1};
    tbl[8]  = '{0, 0, 0, 0, 1, 1, 1, 2};
    tbl[9]  = '{0, 0, 1, 0, 1, 1, 1, 2};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 0, -1};
    tbl[11] = '{1, 0, 0, 0, 1, 0, 0, -1};
    tbl[12] = '{0, 1, 0, 3, 0, 0, 0, -1};

    do_reset();
    chk("rst_request", request, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_level", level, 0);
    chk("rst_seq_err", seq_err, 0);

    for (int i = 0; i < 13; i++) begin
      frame_flag = tbl[i].ff;
      pixel_flag_in = tbl[i].pf;
      out_ready = tbl[i].rdy;
      x_in = 10'(tbl[i].x);
      y_in = '0;
      pixel_in = 18'(100 + tbl[i].x);
      chk($sformatf("v%0d_request", i), request, tbl[i].e_req);
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_val);
      chk($sformatf("v%0d_level", i), level, tbl[i].e_level);
      if (tbl[i].e_x >= 0) begin
        chk($sformatf("v%0d_out_x", i), out_x, tbl[i].e_x);
        chk($sformatf("v%0d_out_pixel", i), out_pixel, 100 + tbl[i].e_x);
      end
      step();
    end
    frame_flag = 1'b0;
    out_ready = 1'b0;

    // Six late returns arrive in DRAIN and must be dropped.
    for (int i = 0; i < 6; i++) begin
      pixel_flag_in = 1'b1;
      chk($sformatf("drain%0d_level", i), level, 0);
      chk($sformatf("drain%0d_request", i), request, 0);
      step();
    end
    pixel_flag_in = 1'b1;
    chk("drain_spurious_request", request, 0);
    step();
    pixel_flag_in = 1'b0;
    chk("drain_resume_request", request, 1);

    // Stall: credit limits the frame to DEPTH outstanding pixels.
    auto_en = 1'b1;
    next_idx = 0;
    pop_idx = 0;
    req_seen = 0;
    pops = 0;
    order_errs = 0;
    max_level = 0;
    repeat (50) step();
    chk("stall_requests", req_seen, 8);
    chk("stall_level", level, 8);
    chk("stall_request", request, 0);
    chk("stall_head_x", out_x, 0);
    out_ready = 1'b1;
    chk("release_request_pre", request, 0);
    step();
    chk("release_request_post", request, 1);
    repeat (9) step();
    chk("stream_level", level, 3);
    chk("stream_request", request, 1);
    repeat (40) step();
    chk("stream_requests", req_seen, NPIX);
    chk("stream_pops", pops, NPIX);
    chk("stream_order", order_errs, 0);
    chk("stream_level_end", level, 0);
    chk("stream_done_request", request, 0);
    chk("stream_max_level", max_level <= 8, 1);
    chk("stream_no_frame_done", fd_count, 0);

    // Whole (shortened) frame ending at (639,479) with random latency.
    do_reset();
    base_idx = FRAME - NPIX;
    lat_min = 4;
    lat_max = 12;
    auto_en = 1'b1;
    start_frame();
    n = 0;
    while (pops < NPIX && n < 600) begin
      out_ready = ($urandom_range(3, 0) != 0);
      step();
      n++;
    end
    chk("frame_wait", n < 600, 1);
    out_ready = 1'b1;
    repeat (5) step();
    chk("frame_requests", req_seen, NPIX);
    chk("frame_pops", pops, NPIX);
    chk("frame_order", order_errs, 0);
    chk("frame_done_count", fd_count, 1);
    chk("frame_done_timing", fd_bad, 0);
    chk("frame_request_off", request, 0);
    chk("frame_max_level", max_level <= 8, 1);
`ifndef LPF_FIFO_SEQ_CHECK_EN
    chk("seq_err_tied", seq_err, 0);
`endif

    // Flush with level 5 and three pixels still in flight.
    do_reset();
    base_idx = 0;
    lat_min = 4;
    lat_max = 4;
    auto_en = 1'b1;
    start_frame();
    n = 0;
    while (!(level == 4'd5 && due_q.size() == 3) && n < 40) begin
      step();
      n++;
    end
    chk("flush_setup_wait", n < 40, 1);
    start_frame();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_level", level, 0);
    n = 0;
    nz = 0;
    while (!request && n < 30) begin
      if (level != 0) nz++;
      step();
      n++;
    end
    chk("flush_resume_wait", n < 30, 1);
    chk("flush_discard", nz, 0);
    chk("flush_level_resume", level, 0);
    out_ready = 1'b1;
    repeat (60) step();
    chk("flush_pops", pops, NPIX);
    chk("flush_order", order_errs, 0);

`ifdef LPF_FIFO_SEQ_CHECK_EN
    do_reset();
    base_idx = 0;
    corrupt_idx = 4;
    auto_en = 1'b1;
    out_ready = 1'b1;
    start_frame();
    repeat (4) step();
    chk("seq_before_error", seq_err, 0);
    repeat (26) step();
    chk("seq_error_set", seq_err, 1);
    corrupt_idx = -1;
    start_frame();
    repeat (5) step();
    chk("seq_error_sticky", seq_err, 1);
    do_reset();
    chk("seq_error_reset", seq_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
